// File: rtl/cpu_ctrl_fsm_if.sv
// Handshake and status bundle between the control sequencer and the core.
// The master side is the sequencer; the slave side is the memories/datapath.
interface cpu_ctrl_fsm_if;
    logic        i_inst_valid;
    logic [31:0] i_inst;
    logic        i_d_valid_data;
    logic [4:0]  o_state;
    logic [31:0] o_inst;
    logic        o_d_MemRead;
    logic        o_d_MemWrite;
    logic        o_reg_we;
    logic        o_finish;
    logic [31:0] o_retired;

    modport master (
        input  i_inst_valid,
        input  i_inst,
        input  i_d_valid_data,
        output o_state,
        output o_inst,
        output o_d_MemRead,
        output o_d_MemWrite,
        output o_reg_we,
        output o_finish,
        output o_retired
    );

    modport slave (
        output i_inst_valid,
        output i_inst,
        output i_d_valid_data,
        input  o_state,
        input  o_inst,
        input  o_d_MemRead,
        input  o_d_MemWrite,
        input  o_reg_we,
        input  o_finish,
        input  o_retired
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the single-issue RV64I core: fetch, decode,
// memory handshakes, register write strobe, retire counter and halt.
module cpu_ctrl_fsm #(
    parameter int DATA_W     = 64,
    parameter int MEM_WR_LAT = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    cpu_ctrl_fsm_if.master    bus
);

    typedef enum logic [4:0] {
        S_FETCH       = 5'd0,
        S_WAIT_INST   = 5'd1,
        S_DECODE      = 5'd2,
        S_EXECUTE     = 5'd3,
        S_MEM_RD      = 5'd4,
        S_MEM_RD_WAIT = 5'd5,
        S_MEM_WR      = 5'd6,
        S_MEM_WR_WAIT = 5'd7,
        S_WRITEBACK   = 5'd8,
        S_PC_UPDATE   = 5'd10,
        S_HALT        = 5'd31
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STOP   = 7'b1111111;

    // Counter reloads with LAT-1 so the wait state lasts exactly LAT cycles.
    localparam logic [4:0] WR_LOAD = 5'(MEM_WR_LAT - 1);

    generate
        if (MEM_WR_LAT < 1 || MEM_WR_LAT > 31) begin : g_bad_wr_lat
            $error("cpu_ctrl_fsm: MEM_WR_LAT must be in 1..31");
        end
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("cpu_ctrl_fsm: DATA_W must be 32 or 64");
        end
    endgenerate

    state_t      state_reg;
    logic [31:0] inst_reg;
    logic        mem_rd_reg;
    logic        mem_wr_reg;
    logic        reg_we_reg;
    logic        finish_reg;
    logic [31:0] retired_reg;
    logic [4:0]  wr_cnt_reg;
    logic [6:0]  opcode;
    logic        opcode_exec;

    assign opcode      = inst_reg[6:0];
    assign opcode_exec = (opcode == OP_LOAD)  || (opcode == OP_STORE) ||
                         (opcode == OP_RTYPE) || (opcode == OP_IALU)  ||
                         (opcode == OP_BRANCH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= S_FETCH;
            inst_reg    <= '0;
            mem_rd_reg  <= 1'b0;
            mem_wr_reg  <= 1'b0;
            reg_we_reg  <= 1'b0;
            finish_reg  <= 1'b0;
            retired_reg <= '0;
            wr_cnt_reg  <= '0;
        end else begin
            // Strobes are set only on the transition into their own state.
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            reg_we_reg <= 1'b0;
            case (state_reg)
                S_FETCH: begin
                    state_reg <= S_WAIT_INST;
                end
                S_WAIT_INST: begin
                    if (bus.i_inst_valid) begin
                        inst_reg  <= bus.i_inst;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_STOP) begin
                        state_reg  <= S_HALT;
                        finish_reg <= 1'b1;
                    end else if (opcode_exec) begin
                        state_reg <= S_EXECUTE;
                    end else begin
                        state_reg <= S_PC_UPDATE;
                    end
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_LOAD: begin
                            state_reg  <= S_MEM_RD;
                            mem_rd_reg <= 1'b1;
                        end
                        OP_STORE: begin
                            state_reg  <= S_MEM_WR;
                            mem_wr_reg <= 1'b1;
                        end
                        OP_RTYPE, OP_IALU: begin
                            state_reg  <= S_WRITEBACK;
                            reg_we_reg <= 1'b1;
                        end
                        default: begin
                            state_reg <= S_PC_UPDATE;
                        end
                    endcase
                end
                S_MEM_RD: begin
                    state_reg <= S_MEM_RD_WAIT;
                end
                S_MEM_RD_WAIT: begin
                    if (bus.i_d_valid_data) begin
                        state_reg  <= S_WRITEBACK;
                        reg_we_reg <= 1'b1;
                    end
                end
                S_MEM_WR: begin
                    wr_cnt_reg <= WR_LOAD;
                    state_reg  <= S_MEM_WR_WAIT;
                end
                S_MEM_WR_WAIT: begin
                    if (wr_cnt_reg == 5'd0) begin
                        state_reg <= S_PC_UPDATE;
                    end else begin
                        wr_cnt_reg <= wr_cnt_reg - 5'd1;
                    end
                end
                S_WRITEBACK: begin
                    state_reg <= S_PC_UPDATE;
                end
                S_PC_UPDATE: begin
                    retired_reg <= retired_reg + 32'd1;
                    state_reg   <= S_FETCH;
                end
                S_HALT: begin
                    finish_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.o_state      = state_reg;
    assign bus.o_inst       = inst_reg;
    assign bus.o_d_MemRead  = mem_rd_reg;
    assign bus.o_d_MemWrite = mem_wr_reg;
    assign bus.o_reg_we     = reg_we_reg;
    assign bus.o_finish     = finish_reg;
    assign bus.o_retired    = retired_reg;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: a vector table of single instructions plus
// hand-written sequences for trace, halt hold and mid-wait reset.
module tb_cpu_ctrl_fsm;

    logic i_clk;
    logic i_rst_n;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm #(.DATA_W(64), .MEM_WR_LAT(5)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks;
    int failures;

    logic [4:0] trace [32];
    int         ntrace;

    typedef struct {
        logic [31:0] inst;
        int          ivd;
        int          dvd;
        bit          spur;
        int          cyc;
        int          rd;
        int          wr;
        int          we;
        int          n5;
        int          n7;
        logic [4:0]  endst;
        int          ret;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"},    32'(bus.o_state), 32'd0);
        chk({tag, "_inst"},     bus.o_inst, 32'd0);
        chk({tag, "_memread"},  32'(bus.o_d_MemRead), 32'd0);
        chk({tag, "_memwrite"}, 32'(bus.o_d_MemWrite), 32'd0);
        chk({tag, "_reg_we"},   32'(bus.o_reg_we), 32'd0);
        chk({tag, "_finish"},   32'(bus.o_finish), 32'd0);
        chk({tag, "_retired"},  bus.o_retired, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        bus.i_inst_valid = 1'b0;
        bus.i_d_valid_data = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Called at a negedge with the FSM in FETCH; returns at the next FETCH or HALT.
    task automatic run_inst(input logic [31:0] inst, input int ivd, input int dvd, input bit spur,
                            output int cyc, output int nrd, output int nwr, output int nwe,
                            output int n5, output int n7, output logic [4:0] end_st);
        int wi;
        int wd;
        logic [4:0] s;
        cyc = 0; nrd = 0; nwr = 0; nwe = 0; n5 = 0; n7 = 0; end_st = 5'h1F;
        wi = 0; wd = 0; ntrace = 0;
        for (int k = 0; k < 200; k++) begin
            s = bus.o_state;
            if (k > 0 && (s == 5'd0 || s == 5'd31)) begin
                end_st = s;
                return;
            end
            if (ntrace < 32) begin
                trace[ntrace] = s;
                ntrace++;
            end
            cyc++;
            chk("memread_only_in_4",  32'(bus.o_d_MemRead),  32'(s == 5'd4));
            chk("memwrite_only_in_6", 32'(bus.o_d_MemWrite), 32'(s == 5'd6));
            chk("reg_we_only_in_8",   32'(bus.o_reg_we),     32'(s == 5'd8));
            chk("finish_only_in_31",  32'(bus.o_finish),     32'(s == 5'd31));
            if (bus.o_d_MemRead)  nrd++;
            if (bus.o_d_MemWrite) nwr++;
            if (bus.o_reg_we)     nwe++;
            if (s == 5'd5) n5++;
            if (s == 5'd7) n7++;
            bus.i_inst_valid   = 1'b0;
            bus.i_d_valid_data = 1'b0;
            bus.i_inst         = 32'h0000007F;
            if (s == 5'd1) begin
                if (wi == ivd) begin
                    bus.i_inst_valid = 1'b1;
                    bus.i_inst       = inst;
                end
                wi++;
            end else if (s == 5'd5) begin
                if (wd == dvd) bus.i_d_valid_data = 1'b1;
                wd++;
            end else if (spur && (s == 5'd2 || s == 5'd3 || s == 5'd6 ||
                                  s == 5'd7 || s == 5'd8 || s == 5'd10)) begin
                bus.i_inst_valid   = 1'b1;
                bus.i_d_valid_data = 1'b1;
            end
            @(negedge i_clk);
        end
        checks++;
        failures++;
        $display("FAIL run_timeout actual_state=%0d required=FETCH_or_HALT within 200 cycles", bus.o_state);
    endtask

    initial begin
        int cyc, nrd, nwr, nwe, n5, n7;
        logic [4:0] end_st;
        logic [31:0] exp_ret;
        logic [4:0] exp_tr [9];
        int bad;
        string nm;

        checks   = 0;
        failures = 0;

        //             inst          ivd dvd spur cyc rd wr we n5 n7 end   ret
        vecs[0] = '{32'h00500093, 2, 0, 1'b0,  8, 0, 0, 1, 0, 0, 5'd0,  1}; // ADDI
        vecs[1] = '{32'h00003083, 0, 3, 1'b0, 11, 1, 0, 1, 4, 0, 5'd0,  1}; // LD slow
        vecs[2] = '{32'h00103023, 1, 0, 1'b1, 12, 0, 1, 0, 0, 5, 5'd0,  1}; // SD
        vecs[3] = '{32'h00208063, 0, 0, 1'b0,  5, 0, 0, 0, 0, 0, 5'd0,  1}; // BEQ
        vecs[4] = '{32'h002081B3, 0, 0, 1'b1,  6, 0, 0, 1, 0, 0, 5'd0,  1}; // ADD
        vecs[5] = '{32'h0000000B, 0, 0, 1'b1,  4, 0, 0, 0, 0, 0, 5'd0,  1}; // illegal
        vecs[6] = '{32'h00003103, 0, 0, 1'b0,  8, 1, 0, 1, 1, 0, 5'd0,  1}; // LD fast
        vecs[7] = '{32'h00000017, 0, 0, 1'b0,  4, 0, 0, 0, 0, 0, 5'd0,  1}; // AUIPC as NOP
        vecs[8] = '{32'h0000007F, 0, 0, 1'b0,  3, 0, 0, 0, 0, 0, 5'd31, 0}; // stop

        exp_tr = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd8, 5'd10, 5'd0};

        i_rst_n = 1'b0;
        bus.i_inst_valid   = 1'b0;
        bus.i_inst         = 32'h0;
        bus.i_d_valid_data = 1'b0;
        repeat (2) @(negedge i_clk);
        chk_reset_values("reset");
        i_rst_n = 1'b1;
        chk("first_cycle_fetch", 32'(bus.o_state), 32'd0);

        exp_ret = 32'd0;
        for (int i = 0; i < 9; i++) begin
            run_inst(vecs[i].inst, vecs[i].ivd, vecs[i].dvd, vecs[i].spur,
                     cyc, nrd, nwr, nwe, n5, n7, end_st);
            exp_ret = exp_ret + 32'(vecs[i].ret);
            nm = $sformatf("v%0d", i);
            chk({nm, "_cycles"},  32'(cyc), 32'(vecs[i].cyc));
            chk({nm, "_memread"}, 32'(nrd), 32'(vecs[i].rd));
            chk({nm, "_memwr"},   32'(nwr), 32'(vecs[i].wr));
            chk({nm, "_reg_we"},  32'(nwe), 32'(vecs[i].we));
            chk({nm, "_n_st5"},   32'(n5),  32'(vecs[i].n5));
            chk({nm, "_n_st7"},   32'(n7),  32'(vecs[i].n7));
            chk({nm, "_end"},     32'(end_st), 32'(vecs[i].endst));
            chk({nm, "_inst"},    bus.o_inst, vecs[i].inst);
            chk({nm, "_retired"}, bus.o_retired, exp_ret);
            $display("vec %0d inst=%08h cycles=%0d rd=%0d wr=%0d we=%0d retired=%0d",
                     i, vecs[i].inst, cyc, nrd, nwr, nwe, bus.o_retired);
        end
        chk("halt_finish", 32'(bus.o_finish), 32'd1);

        // ADDI with three WAIT_INST cycles: exact state trace.
        apply_reset();
        run_inst(32'h00500093, 2, 0, 1'b0, cyc, nrd, nwr, nwe, n5, n7, end_st);
        for (int k = 0; k < 8; k++)
            chk($sformatf("addi_trace_%0d", k), 32'(trace[k]), 32'(exp_tr[k]));
        chk("addi_trace_end", 32'(end_st), 32'(exp_tr[8]));
        chk("addi_trace_len", 32'(ntrace), 32'd8);
        chk("addi_retired", bus.o_retired, 32'd1);
        $display("seq addi_trace cycles=%0d retired=%0d", cyc, bus.o_retired);

        // BEQ then stop; HALT must hold for 100 cycles despite spurious inputs.
        apply_reset();
        run_inst(32'h00208063, 0, 0, 1'b0, cyc, nrd, nwr, nwe, n5, n7, end_st);
        chk("beq_cycles", 32'(cyc), 32'd5);
        chk("beq_strobes", 32'(nrd + nwr + nwe), 32'd0);
        run_inst(32'h0000007F, 0, 0, 1'b0, cyc, nrd, nwr, nwe, n5, n7, end_st);
        chk("stop_end", 32'(end_st), 32'd31);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            bus.i_inst_valid   = k[0];
            bus.i_d_valid_data = ~k[0];
            bus.i_inst         = 32'h00000013;
            @(negedge i_clk);
            if (bus.o_state !== 5'd31 || bus.o_finish !== 1'b1 ||
                bus.o_reg_we !== 1'b0 || bus.o_d_MemRead !== 1'b0 || bus.o_d_MemWrite !== 1'b0)
                bad++;
        end
        bus.i_inst_valid   = 1'b0;
        bus.i_d_valid_data = 1'b0;
        chk("halt_hold_bad_cycles", 32'(bad), 32'd0);
        chk("halt_retired", bus.o_retired, 32'd1);
        chk("halt_inst", bus.o_inst, 32'h0000007F);
        $display("seq beq_halt bad_cycles=%0d retired=%0d", bad, bus.o_retired);

        // Reset asserted while waiting in MEM_RD_WAIT.
        apply_reset();
        run_inst(32'h0000000B, 0, 0, 1'b0, cyc, nrd, nwr, nwe, n5, n7, end_st);
        chk("pre_reset_retired", bus.o_retired, 32'd1);
        bad = 1;
        for (int k = 0; k < 20; k++) begin
            bus.i_inst_valid   = (bus.o_state == 5'd1);
            bus.i_inst         = 32'h00003083;
            bus.i_d_valid_data = 1'b0;
            if (bus.o_state == 5'd5) begin
                bad = 0;
                break;
            end
            @(negedge i_clk);
        end
        chk("reached_mem_rd_wait", 32'(bad), 32'd0);
        bus.i_inst_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("still_mem_rd_wait", 32'(bus.o_state), 32'd5);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        @(negedge i_clk);
        chk_reset_values("held_reset");
        i_rst_n = 1'b1;
        chk("restart_fetch", 32'(bus.o_state), 32'd0);
        @(posedge i_clk);
        #1;
        chk("restart_wait_inst", 32'(bus.o_state), 32'd1);
        $display("seq reset_in_wait state_after_release=%0d", bus.o_state);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
